// File: rtl/sram_arbiter.sv
// Round-robin arbiter sharing one single-port SRAM among NUM_REQ requesters.
// Supports locked bursts and routes one-cycle-latency read data back to the issuer.
module sram_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 128,
    parameter int DEPTH      = 2048,
    parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [NUM_REQ-1:0]               req_valid,
    output logic [NUM_REQ-1:0]               req_ready,
    input  logic [NUM_REQ-1:0]               req_we,
    input  logic [NUM_REQ-1:0]               req_last,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]    req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]    req_wdata,
    output logic [NUM_REQ-1:0]               rsp_valid,
    output logic [DATA_WIDTH-1:0]            rsp_rdata,
    output logic                             sram_en,
    output logic                             sram_we,
    output logic [ADDR_WIDTH-1:0]            sram_addr,
    output logic [DATA_WIDTH-1:0]            sram_wdata,
    input  logic [DATA_WIDTH-1:0]            sram_rdata,
    output logic                             busy
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    state_t               state_r, state_nxt_s;
    logic [PTR_W-1:0]     rr_ptr_r, rr_ptr_nxt_s;
    logic [PTR_W-1:0]     lock_id_r, lock_id_nxt_s;
    logic [NUM_REQ-1:0]   rsp_pend_r, rsp_pend_nxt_s;
    logic                 grant_vld_s;
    logic [PTR_W-1:0]     grant_id_s;
    logic [PTR_W-1:0]     scan_idx_s;

    // Grant selection: locked owner only, else first valid scanning from rr_ptr.
    always_comb begin
        grant_vld_s = 1'b0;
        grant_id_s  = '0;
        scan_idx_s  = '0;
        if (state_r == ST_LOCKED) begin
            if (req_valid[lock_id_r]) begin
                grant_vld_s = 1'b1;
                grant_id_s  = lock_id_r;
            end else begin
                grant_vld_s = 1'b0;
            end
        end else begin
            // Scan from the far end so the closest-to-pointer valid wins last.
            for (int k = NUM_REQ - 1; k >= 0; k--) begin
                scan_idx_s = PTR_W'((int'(rr_ptr_r) + k) % NUM_REQ);
                if (req_valid[scan_idx_s]) begin
                    grant_vld_s = 1'b1;
                    grant_id_s  = scan_idx_s;
                end else begin
                    grant_vld_s = grant_vld_s;
                end
            end
        end
        if (rst) begin
            grant_vld_s = 1'b0;
        end else begin
            grant_vld_s = grant_vld_s;
        end
    end

    // SRAM control and ready strobe, steered from the granted slot.
    always_comb begin
        req_ready  = '0;
        sram_en    = 1'b0;
        sram_we    = 1'b0;
        sram_addr  = '0;
        sram_wdata = '0;
        if (grant_vld_s) begin
            req_ready  = {{(NUM_REQ-1){1'b0}}, 1'b1} << grant_id_s;
            sram_en    = 1'b1;
            sram_we    = req_we[grant_id_s];
            sram_addr  = req_addr[grant_id_s*ADDR_WIDTH +: ADDR_WIDTH];
            sram_wdata = req_wdata[grant_id_s*DATA_WIDTH +: DATA_WIDTH];
        end else begin
            sram_en = 1'b0;
        end
    end

    // Next-state: lock on non-final beats, release and advance pointer on final beats.
    always_comb begin
        state_nxt_s    = state_r;
        rr_ptr_nxt_s   = rr_ptr_r;
        lock_id_nxt_s  = lock_id_r;
        rsp_pend_nxt_s = '0;
        if (grant_vld_s) begin
            if (req_last[grant_id_s]) begin
                state_nxt_s  = ST_IDLE;
                rr_ptr_nxt_s = PTR_W'((int'(grant_id_s) + 1) % NUM_REQ);
            end else begin
                state_nxt_s   = ST_LOCKED;
                lock_id_nxt_s = grant_id_s;
            end
            if (!req_we[grant_id_s]) begin
                rsp_pend_nxt_s = {{(NUM_REQ-1){1'b0}}, 1'b1} << grant_id_s;
            end else begin
                rsp_pend_nxt_s = '0;
            end
        end else begin
            state_nxt_s = state_r;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            rr_ptr_r   <= '0;
            lock_id_r  <= '0;
            rsp_pend_r <= '0;
        end else begin
            state_r    <= state_nxt_s;
            rr_ptr_r   <= rr_ptr_nxt_s;
            lock_id_r  <= lock_id_nxt_s;
            rsp_pend_r <= rsp_pend_nxt_s;
        end
    end

    assign rsp_valid = rsp_pend_r;
    assign rsp_rdata = sram_rdata;
    assign busy      = (state_r == ST_LOCKED);

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed testbench for sram_arbiter with a behavioural one-cycle-latency SRAM.
module tb_sram_arbiter;
    localparam int N  = 4;
    localparam int DW = 128;
    localparam int AW = 11;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    req_valid, req_ready, req_we, req_last, rsp_valid;
    logic [N*AW-1:0] req_addr;
    logic [N*DW-1:0] req_wdata;
    logic [DW-1:0]   rsp_rdata, sram_wdata, sram_rdata;
    logic            sram_en, sram_we, busy;
    logic [AW-1:0]   sram_addr;
    logic [DW-1:0]   mem [0:2047];

    int total = 0;
    int bad   = 0;

    sram_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .DEPTH(2048)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_we(req_we), .req_last(req_last), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .sram_en(sram_en), .sram_we(sram_we),
        .sram_addr(sram_addr), .sram_wdata(sram_wdata), .sram_rdata(sram_rdata), .busy(busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (sram_en && sram_we) mem[sram_addr] <= sram_wdata;
        if (sram_en && !sram_we) sram_rdata <= mem[sram_addr];
    end

    function automatic logic [DW-1:0] dpat(input int k);
        return {4{32'hC0DE_0000 + 32'(k)}};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic v, input logic we, input logic last,
                           input logic [AW-1:0] a, input logic [DW-1:0] d);
        req_valid[i] = v;
        req_we[i]    = we;
        req_last[i]  = last;
        req_addr[i*AW +: AW] = a;
        req_wdata[i*DW +: DW] = d;
    endtask

    task automatic clear_all();
        for (int i = 0; i < N; i++) set_req(i, 1'b0, 1'b0, 1'b1, 11'd0, 128'd0);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        clear_all();
        step();
        for (int i = 0; i < N; i++) set_req(i, 1'b1, 1'b1, 1'b0, 11'(i), dpat(i));
        for (int c = 0; c < 2; c++) begin
            #1;
            total++; if (req_ready !== 4'b0000) begin bad++; $display("FAIL rst_ready got=%b exp=0000", req_ready); end
            total++; if (sram_en !== 1'b0 || sram_we !== 1'b0) begin bad++; $display("FAIL rst_sram got en=%b we=%b exp 0 0", sram_en, sram_we); end
            total++; if (busy !== 1'b0 || rsp_valid !== 4'b0000) begin bad++; $display("FAIL rst_state got busy=%b rsp=%b exp 0 0000", busy, rsp_valid); end
            step();
        end
        clear_all();
        rst = 1'b0;
        step();
    endtask

    task automatic test_single_read();
        set_req(0, 1'b1, 1'b1, 1'b1, 11'd5, {16{8'hA5}});
        #1;
        total++; if (req_ready !== 4'b0001 || sram_en !== 1'b1 || sram_we !== 1'b1) begin bad++; $display("FAIL sr_wr_grant got ready=%b en=%b we=%b exp 0001 1 1", req_ready, sram_en, sram_we); end
        total++; if (sram_addr !== 11'd5 || sram_wdata !== {16{8'hA5}}) begin bad++; $display("FAIL sr_wr_data got addr=%0d data=%h exp 5 a5..", sram_addr, sram_wdata); end
        step();
        clear_all();
        set_req(2, 1'b1, 1'b0, 1'b1, 11'd5, 128'd0);
        #1;
        total++; if (req_ready !== 4'b0100 || sram_we !== 1'b0 || sram_addr !== 11'd5) begin bad++; $display("FAIL sr_rd_grant got ready=%b we=%b addr=%0d exp 0100 0 5", req_ready, sram_we, sram_addr); end
        total++; if (rsp_valid !== 4'b0000) begin bad++; $display("FAIL sr_wr_norsp got=%b exp=0000", rsp_valid); end
        step();
        clear_all();
        #1;
        total++; if (rsp_valid !== 4'b0100) begin bad++; $display("FAIL sr_rsp_valid got=%b exp=0100", rsp_valid); end
        total++; if (rsp_rdata !== {16{8'hA5}}) begin bad++; $display("FAIL sr_rsp_data got=%h exp=a5..a5", rsp_rdata); end
        step();
        total++; if (rsp_valid !== 4'b0000) begin bad++; $display("FAIL sr_rsp_once got=%b exp=0000", rsp_valid); end
    endtask

    task automatic test_round_robin();
        logic [N-1:0] exp_g [5];
        exp_g = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        // rr_ptr is 3 here; a single write from requester 3 wraps it to 0.
        set_req(3, 1'b1, 1'b1, 1'b1, 11'd13, dpat(13));
        #1;
        total++; if (req_ready !== 4'b1000) begin bad++; $display("FAIL rr_setup got=%b exp=1000", req_ready); end
        step();
        for (int i = 0; i < N; i++) set_req(i, 1'b1, 1'b0, 1'b1, 11'd5, 128'd0);
        for (int k = 0; k < 5; k++) begin
            #1;
            total++; if (req_ready !== exp_g[k] || sram_en !== 1'b1) begin bad++; $display("FAIL rr_grant%0d got ready=%b en=%b exp %b 1", k, req_ready, sram_en, exp_g[k]); end
            total++; if (rsp_valid !== ((k == 0) ? 4'b0000 : exp_g[k-1])) begin bad++; $display("FAIL rr_rsp%0d got=%b exp=%b", k, rsp_valid, (k == 0) ? 4'b0000 : exp_g[k-1]); end
            step();
        end
        clear_all();
        #1;
        total++; if (rsp_valid !== 4'b0001 || rsp_rdata !== {16{8'hA5}}) begin bad++; $display("FAIL rr_rsp_last got rsp=%b data=%h exp 0001 a5..", rsp_valid, rsp_rdata); end
        step();
    endtask

    task automatic test_burst_lock();
        // rr_ptr is 1, so requester 1 wins and then holds the port.
        set_req(0, 1'b1, 1'b0, 1'b1, 11'd5, 128'd0);
        set_req(2, 1'b1, 1'b0, 1'b1, 11'd5, 128'd0);
        set_req(3, 1'b1, 1'b0, 1'b1, 11'd5, 128'd0);
        for (int k = 0; k < 4; k++) begin
            set_req(1, 1'b1, 1'b1, (k == 3), 11'(40 + k), dpat(40 + k));
            #1;
            total++; if (req_ready !== 4'b0010 || sram_we !== 1'b1 || sram_addr !== 11'(40 + k)) begin bad++; $display("FAIL bl_beat%0d got ready=%b we=%b addr=%0d exp 0010 1 %0d", k, req_ready, sram_we, sram_addr, 40 + k); end
            total++; if (busy !== (k != 0)) begin bad++; $display("FAIL bl_busy%0d got=%b exp=%b", k, busy, (k != 0)); end
            step();
        end
        set_req(1, 1'b0, 1'b0, 1'b1, 11'd0, 128'd0);
        #1;
        total++; if (busy !== 1'b0 || req_ready !== 4'b0100) begin bad++; $display("FAIL bl_next got busy=%b ready=%b exp 0 0100", busy, req_ready); end
        step();
        clear_all();
        step();
    endtask

    task automatic test_burst_gap();
        // rr_ptr is 3; requester 0 stays valid throughout and must stall.
        set_req(0, 1'b1, 1'b0, 1'b1, 11'd5, 128'd0);
        set_req(3, 1'b1, 1'b0, 1'b0, 11'd40, 128'd0);
        #1;
        total++; if (req_ready !== 4'b1000) begin bad++; $display("FAIL bg_b0 got=%b exp=1000", req_ready); end
        step();
        set_req(3, 1'b1, 1'b0, 1'b0, 11'd41, 128'd0);
        #1;
        total++; if (req_ready !== 4'b1000 || busy !== 1'b1) begin bad++; $display("FAIL bg_b1 got ready=%b busy=%b exp 1000 1", req_ready, busy); end
        total++; if (rsp_valid !== 4'b1000 || rsp_rdata !== dpat(40)) begin bad++; $display("FAIL bg_rsp40 got rsp=%b data=%h exp 1000 %h", rsp_valid, rsp_rdata, dpat(40)); end
        step();
        set_req(3, 1'b0, 1'b0, 1'b0, 11'd42, 128'd0);
        for (int g = 0; g < 2; g++) begin
            #1;
            total++; if (req_ready !== 4'b0000 || sram_en !== 1'b0 || sram_addr !== 11'd0) begin bad++; $display("FAIL bg_gap%0d got ready=%b en=%b addr=%0d exp 0000 0 0", g, req_ready, sram_en, sram_addr); end
            total++; if (busy !== 1'b1) begin bad++; $display("FAIL bg_gapbusy%0d got=%b exp=1", g, busy); end
            if (g == 0) begin
                total++; if (rsp_valid !== 4'b1000 || rsp_rdata !== dpat(41)) begin bad++; $display("FAIL bg_rsp41 got rsp=%b data=%h exp 1000 %h", rsp_valid, rsp_rdata, dpat(41)); end
            end else begin
                total++; if (rsp_valid !== 4'b0000) begin bad++; $display("FAIL bg_gaprsp got=%b exp=0000", rsp_valid); end
            end
            step();
        end
        set_req(3, 1'b1, 1'b0, 1'b0, 11'd42, 128'd0);
        #1;
        total++; if (req_ready !== 4'b1000) begin bad++; $display("FAIL bg_b2 got=%b exp=1000", req_ready); end
        step();
        set_req(3, 1'b1, 1'b0, 1'b1, 11'd43, 128'd0);
        #1;
        total++; if (req_ready !== 4'b1000 || rsp_rdata !== dpat(42)) begin bad++; $display("FAIL bg_b3 got ready=%b data=%h exp 1000 %h", req_ready, rsp_rdata, dpat(42)); end
        step();
        set_req(3, 1'b0, 1'b0, 1'b1, 11'd0, 128'd0);
        #1;
        total++; if (req_ready !== 4'b0001 || busy !== 1'b0) begin bad++; $display("FAIL bg_release got ready=%b busy=%b exp 0001 0", req_ready, busy); end
        total++; if (rsp_valid !== 4'b1000 || rsp_rdata !== dpat(43)) begin bad++; $display("FAIL bg_rsp43 got rsp=%b data=%h exp 1000 %h", rsp_valid, rsp_rdata, dpat(43)); end
        step();
        clear_all();
        step();
    endtask

    task automatic test_reset_mid_burst();
        // rr_ptr is 1; requester 2 alone locks the port for two beats.
        set_req(2, 1'b1, 1'b0, 1'b0, 11'd5, 128'd0);
        #1;
        total++; if (req_ready !== 4'b0100) begin bad++; $display("FAIL rm_b0 got=%b exp=0100", req_ready); end
        step();
        #1;
        total++; if (req_ready !== 4'b0100 || busy !== 1'b1) begin bad++; $display("FAIL rm_b1 got ready=%b busy=%b exp 0100 1", req_ready, busy); end
        step();
        rst = 1'b1;
        #1;
        total++; if (req_ready !== 4'b0000 || sram_en !== 1'b0) begin bad++; $display("FAIL rm_rstgate got ready=%b en=%b exp 0000 0", req_ready, sram_en); end
        step();
        rst = 1'b0;
        for (int i = 0; i < N; i++) set_req(i, 1'b1, 1'b0, 1'b1, 11'd5, 128'd0);
        #1;
        total++; if (rsp_valid !== 4'b0000 || busy !== 1'b0) begin bad++; $display("FAIL rm_after got rsp=%b busy=%b exp 0000 0", rsp_valid, busy); end
        total++; if (req_ready !== 4'b0001) begin bad++; $display("FAIL rm_first got=%b exp=0001", req_ready); end
        step();
        clear_all();
        #1;
        total++; if (rsp_valid !== 4'b0001) begin bad++; $display("FAIL rm_rsp got=%b exp=0001", rsp_valid); end
        step();
    endtask

    task automatic test_raw();
        set_req(0, 1'b1, 1'b1, 1'b1, 11'd100, 128'h1234);
        #1;
        total++; if (req_ready !== 4'b0001 || sram_we !== 1'b1) begin bad++; $display("FAIL raw_wr got ready=%b we=%b exp 0001 1", req_ready, sram_we); end
        step();
        set_req(0, 1'b1, 1'b0, 1'b1, 11'd100, 128'h0);
        #1;
        total++; if (req_ready !== 4'b0001 || sram_we !== 1'b0 || sram_addr !== 11'd100) begin bad++; $display("FAIL raw_rd got ready=%b we=%b addr=%0d exp 0001 0 100", req_ready, sram_we, sram_addr); end
        step();
        clear_all();
        #1;
        total++; if (rsp_valid !== 4'b0001 || rsp_rdata !== 128'h1234) begin bad++; $display("FAIL raw_rsp got rsp=%b data=%h exp 0001 1234", rsp_valid, rsp_rdata); end
        step();
    endtask

    initial begin
        rst = 1'b1;
        req_valid = '0; req_we = '0; req_last = '0; req_addr = '0; req_wdata = '0;
        test_reset();
        test_single_read();
        test_round_robin();
        test_burst_lock();
        test_burst_gap();
        test_reset_mid_burst();
        test_raw();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/sram_arbiter.md
# sram_arbiter

Round-robin arbiter that shares one single-port SRAM (weight or activation buffer) among NUM_REQ requesters such as the DMA fill engine and compute-array fetch units. It issues at most one access per cycle and supports locked bursts, so a requester can own the port for a contiguous sequence. It returns read data to the issuing requester, aligned with the SRAM's one-cycle read latency.

## Interface
- NUM_REQ, 4, number of requesters (2..8)
- DATA_WIDTH, 128, SRAM word width
- DEPTH, 2048, SRAM words
- ADDR_WIDTH, $clog2(DEPTH), address width
- clk  in  1  clock; all logic on posedge
- rst  in  1  reset, synchronous, active-high
- req_valid  in  NUM_REQ  per-requester access request
- req_ready  out  NUM_REQ  beat accepted this cycle (one-hot or zero)
- req_we  in  NUM_REQ  1 = write, 0 = read
- req_last  in  NUM_REQ  1 = final beat of burst (single beats drive 1)
- req_addr  in  NUM_REQ*ADDR_WIDTH  packed addresses; requester i at [i*ADDR_WIDTH +: ADDR_WIDTH]
- req_wdata  in  NUM_REQ*DATA_WIDTH  packed write data, same packing
- rsp_valid  out  NUM_REQ  read data valid for requester i
- rsp_rdata  out  DATA_WIDTH  read data, shared by all requesters
- sram_en  out  1  SRAM enable
- sram_we  out  1  SRAM write enable
- sram_addr  out  ADDR_WIDTH  SRAM address
- sram_wdata  out  DATA_WIDTH  SRAM write data
- sram_rdata  in  DATA_WIDTH  SRAM read data, valid the cycle after a read-enabled edge
- busy  out  1  arbiter is in LOCKED state

## Operation
- State: rr_ptr (clog2(NUM_REQ) bits), lock_id, FSM {IDLE, LOCKED}, rsp_pend (NUM_REQ bits, registered).
- IDLE grant: the first i with req_valid[i]=1, scanning rr_ptr, rr_ptr+1, … modulo NUM_REQ. That requester gets req_ready[i]=1. No valids gives no grant.
- LOCKED grant: only lock_id is eligible. If req_valid[lock_id]=0, there is no grant, the SRAM idles and all other requesters stall.
- Accepted beat from i: sram_en=1, sram_we=req_we[i], sram_addr and sram_wdata are taken from slot i. All four are combinational in the same cycle.
- No accepted beat: sram_en=0, sram_we=0, addr and wdata are don't-care (drive 0).
- Transitions:
  - IDLE → LOCKED on an accepted beat with req_last=0; lock_id←i.
  - LOCKED → IDLE on an accepted beat with req_last=1.
  - An IDLE beat with req_last=1 stays in IDLE.
- rr_ptr is updated only on a beat with req_last=1: rr_ptr←(i+1) mod NUM_REQ. It is unchanged during a burst.
- Read response: an accepted read from i sets rsp_pend←one-hot(i) at the edge; otherwise rsp_pend←0.
  - rsp_valid=rsp_pend.
  - rsp_rdata=sram_rdata (passthrough).
  - Responses cannot be back-pressured.
- Writes produce no response. Read-after-write to the same address on consecutive cycles returns the new data, because the SRAM writes at the first edge.

## Timing
- Arbitration and SRAM control: 0 cycles, combinational from req_* and registered state.
- req_ready must not depend on req_ready of any other requester.
- Read latency: a beat accepted at edge N gives rsp_valid high for exactly one cycle after edge N, aligned with sram_rdata.
- Throughput: 1 beat per cycle, sustained. Back-to-back grants to different requesters are allowed in IDLE with no bubble.
- While rst=1, these are forced to 0: req_ready, sram_en, sram_we.
- At the first edge with rst=1:
  - FSM←IDLE, lock_id←0, rr_ptr←0, rsp_pend←0.
  - Consequently rsp_valid=0 and busy=0 in the following cycle.
- Reset mid-burst drops the lock. A read accepted in the same cycle as a reset edge produces no response.
- req_last on a write beat ends a burst exactly like a read.
- A burst may mix reads and writes.
- Requesters hold req_valid, addr, wdata, we and last stable until req_ready (valid/ready rule). The arbiter does not check this.

## Test plan
- Single read: after reset, write 0xA5…A5 to addr 5 from req 0 (last=1), then read addr 5 from req 2 → rsp_valid=4'b0100 one cycle after the accept, rsp_rdata=0xA5…A5, all other rsp_valid bits 0.
- Round-robin: all 4 requesters hold single-beat reads with rr_ptr=0 → grant order 0,1,2,3,0 on consecutive cycles, no bubbles. rsp_valid walks one-hot one cycle behind the grants.
- Burst lock: req 1 issues 4 beats (last on the 4th) while reqs 0, 2 and 3 are valid → only req 1 is granted for 4 cycles and busy=1 through the 3rd accept edge. Next grant goes to req 2 (rr_ptr=2).
- Burst gap: req 3 locked, deasserts req_valid for 2 cycles mid-burst while req 0 is valid → sram_en=0 and req_ready=0 for those 2 cycles; req 3 then resumes and finishes.
- Reset mid-burst: req 2 locked after 2 beats, rst pulsed 1 cycle with a read accepted on the reset edge → no rsp_valid afterwards, busy=0, rr_ptr=0. Requester 0 is granted first once rst=0.
- RAW back-to-back: req 0 writes 0x1234 to addr 100, then reads addr 100 next cycle → rsp_rdata=0x1234 with rsp_valid[0]=1.
